tm_multi_ptr_ctrl: RTL
======================

// Module: tm_multi_ptr_ctrl
// PURPOSE
//  Next-gen RAM-disk controller core for the Apple II slot card: N auto-advancing RAM pointers
//  behind one /DEVSEL register window, plus ROM bank register and PHI1-synchronised bus timing.
//  Sits between slot bus (A, D, R/W, select strobes) and SRAM address/CS pins.
//  Delayed/hold-fixed PHI1 is generated outside this block.
// PARAMETERS
//  ADDR_W  20  RAM pointer width, legal 17..24.
//  CH      2   Pointer channel count, legal 1..3.
//  STEP_W  4   Width of the global step register.
// PORTS
//  C7M      in   1        7M bus clock; all state on posedge C7M.
//  RES      in   1        Async reset, active-high.
//  PHI1     in   1        Conditioned PHI1.
//  A        in   4        Slot address A[3:0].
//  nWE      in   1        6502 R/W, low = write.
//  nDEVSEL  in   1        Register window select, active-low.
//  D_in     in   8        Slot data bus in.
//  D_out    out  8        Readback data for pointer and config registers.
//  D_oe     out  1        Drive slot bus with D_out, or with RD when RD_sel=1.
//  RD_sel   out  1        1: current access is a data port; slot data comes from RAM.
//  RA       out  ADDR_W   SRAM address.
//  RAMCS    out  1        SRAM chip select, active-high.
//  DBEN     out  1        Data-bus driver window.
//  BANK     out  8        ROM bank register.
// BEHAVIOUR
//  Reset: all pointers=0, BANK=0, STEP=1, DIR=0, S=0, PHI0seen=0, pending=0,
//   DBEN=CSEN=0, D_oe=0, RAMCS=0, D_out=0.
//  State counter S[2:0]:
//   - S<=1 when PHI1 & ~PHI1q & PHI0seen.
//   - else S=0 holds, S=7 holds, otherwise S+1.
//   - PHI0seen set on any cycle with ~PHI1.
//  DBEN <= S in 4..7.
//  CSEN <= (S==4 & nWE) | S in 5..7.
//  Register map, offset A[3:0], channel c<CH:
//   - 4c+0/1/2: pointer L/M/H byte, R/W.
//   - 4c+3: data port c.
//   - 0xD: STEP, R/W.
//   - 0xE: DIR, R/W.
//   - 0xF: BANK, R/W.
//   - All other offsets read 0x00; writes ignored.
//  Readback of pointer H byte = {1-pad, ptr[ADDR_W-1:16]}; bits above ADDR_W-1 read 1.
//  Register writes commit at S==6 from D_in when ~nDEVSEL & ~nWE.
//  Byte writes load only that byte: no carry, no pending clear.
//  Data port access (~nDEVSEL, port c, R or W) at S==6 sets pend[c].
//  At next S==1, ptr[c] <= ptr[c] ± STEP (full-width add, mod 2^ADDR_W), then pend[c] clears.
//   - Wrap FFFFF->00000 is silent.
//   - STEP=0 means no movement.
//  RA = ptr of the channel addressed by A when A is a data port, else ptr of the last data-port channel.
//  RAMCS = ~nDEVSEL & dataport(A) & CSEN.
//  RD_sel = dataport(A).
//  D_oe = DBEN & nWE & ~nDEVSEL.
//  Latency: data-port access at S6 -> pointer advanced by S1 of the next bus cycle.
//  Back-to-back accesses always see the advanced pointer.
//  Reset mid-cycle: S returns to 0; nothing advances until PHI0 then a PHI1 rising edge.
// CONFIGURATION
//  TM_DEC_MODE_EN defined:
//   - 0xE bit c = DIR[c]; 1 = decrement by STEP.
//  TM_DEC_MODE_EN undefined:
//   - 0xE reads 0x00; writes ignored; always increment.
// STRUCTURE
//  Package tm_pkg:
//   - S state localparams S0..S7.
//   - Register offset constants: PTRL/PTRM/PTRH/DPORT stride 4, STEP=0xD, DIR=0xE, BANK=0xF.
//  Sub-module tm_ptr_chan, instantiated CH times:
//   - Holds one pointer plus its pend flag.
//   - Byte load, step add/sub, readback mux.
// TESTING
//  T1 reset: RES pulse -> RA=0, BANK=0, RAMCS=0, D_oe=0, S=0 until first PHI0->PHI1.
//  T2 write ptr0 H/M/L=0x0F,0xFF,0xFF, then read port 3 -> RA=0xFFFFF during access; next access RA=0x00000.
//  T3 STEP=4, 3 reads of port 7 (ch1) from 0x00100 -> RA 0x00100, 0x00104, 0x00108; ch0 unchanged.
//  T4 TM_DEC_MODE_EN, DIR=0x01, STEP=1, ch0 from 0x00000 -> one access, then ptr0 reads H/M/L=0xFF,0xFF,0xFF.
//  T5 read of offset 0xC -> D_out=0x00, D_oe=1 S4..7.
//     Write 0xF=0x5A -> BANK=0x5A after S6.
//     RAMCS stays 0 for the whole sequence.
//  T6 RES asserted at S5 of a data-port access -> no pointer advance; pend cleared.

Source files
------------

// File: rtl/tm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : tm_pkg                                                        |
// | Description: Shared constants for the multi-pointer RAM-disk controller:  |
// |              bus-timing state codes and register-window offsets.           |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package tm_pkg;

  // Bus-timing state counter codes
  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4;
  localparam logic [2:0] S5 = 3'd5;
  localparam logic [2:0] S6 = 3'd6;
  localparam logic [2:0] S7 = 3'd7;

  // Per-channel register offsets within a stride-4 block
  localparam int         OFS_STRIDE = 4;
  localparam logic [1:0] OFS_PTRL   = 2'd0;
  localparam logic [1:0] OFS_PTRM   = 2'd1;
  localparam logic [1:0] OFS_PTRH   = 2'd2;
  localparam logic [1:0] OFS_DPORT  = 2'd3;

  // Global register offsets
  localparam logic [3:0] OFS_STEP = 4'hD;
  localparam logic [3:0] OFS_DIR  = 4'hE;
  localparam logic [3:0] OFS_BANK = 4'hF;

  // True when offset a is the data port of an implemented channel
  function automatic logic is_dport(input logic [3:0] a, input int ch);
    return (a[1:0] == OFS_DPORT) && (int'(a[3:2]) < ch);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tm_ptr_chan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tm_ptr_chan                                                   |
// | Description: One auto-advancing RAM pointer with its pending-advance flag, |
// |              byte-wise load, step add/subtract and byte readback.          |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tm_ptr_chan
  import tm_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int STEP_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_i,
  input  logic [1:0]        byte_i,
  input  logic [7:0]        wdata_i,
  input  logic              acc_i,
  input  logic              adv_i,
  input  logic              dec_i,
  input  logic [STEP_W-1:0] step_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic [7:0]        rdata_o
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] w_step;
  logic [7:0]        w_hi;

  assign w_step = {{(ADDR_W-STEP_W){1'b0}}, step_i};

  // Next pointer: pending advance at S1 wins; byte loads never touch the pending flag
  always_comb begin
    ptr_d  = ptr_q;
    pend_d = pend_q;
    if (adv_i && pend_q) begin
      ptr_d  = dec_i ? (ptr_q - w_step) : (ptr_q + w_step);
      pend_d = 1'b0;
    end else begin
      if (wr_i) begin
        case (byte_i)
          OFS_PTRL: ptr_d[7:0]         = wdata_i;
          OFS_PTRM: ptr_d[15:8]        = wdata_i;
          OFS_PTRH: ptr_d[ADDR_W-1:16] = wdata_i[ADDR_W-17:0];
          default:  ptr_d              = ptr_q;
        endcase
      end
      if (acc_i) pend_d = 1'b1;
    end
  end

  // Pointer and pending-flag registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      pend_q <= pend_d;
    end
  end

  // Readback byte select; bits of the high byte beyond the pointer read as 1
  always_comb begin
    w_hi                = 8'hFF;
    w_hi[ADDR_W-17:0]   = ptr_q[ADDR_W-1:16];
    case (byte_i)
      OFS_PTRL: rdata_o = ptr_q[7:0];
      OFS_PTRM: rdata_o = ptr_q[15:8];
      OFS_PTRH: rdata_o = w_hi;
      default:  rdata_o = 8'h00;
    endcase
  end

  assign ptr_o = ptr_q;

endmodule
`default_nettype wire

// File: rtl/tm_multi_ptr_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tm_multi_ptr_ctrl                                             |
// | Description: RAM-disk controller core: CH auto-advancing RAM pointers in  |
// |              one /DEVSEL register window, ROM bank register, and the      |
// |              PHI1-synchronised bus timing that gates DBEN/RAMCS.           |
// |              Optional feature macro: TM_DEC_MODE_EN (per-channel          |
// |              decrement direction register at offset 0xE).                 |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tm_multi_ptr_ctrl
  import tm_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int CH     = 2,
  parameter int STEP_W = 4
) (
  input  logic              C7M,
  input  logic              RES,
  input  logic              PHI1,
  input  logic [3:0]        A,
  input  logic              nWE,
  input  logic              nDEVSEL,
  input  logic [7:0]        D_in,
  output logic [7:0]        D_out,
  output logic              D_oe,
  output logic              RD_sel,
  output logic [ADDR_W-1:0] RA,
  output logic              RAMCS,
  output logic              DBEN,
  output logic [7:0]        BANK
);

  logic [2:0]        s_q;
  logic              phi1_q;
  logic              phi0seen_q;
  logic              dben_q;
  logic              csen_q;
  logic [STEP_W-1:0] step_q;
  logic [7:0]        bank_q;
  logic [7:0]        dout_q;
  logic [1:0]        last_q;
`ifdef TM_DEC_MODE_EN
  logic [CH-1:0]     dir_q;
`endif

  logic              w_sel;
  logic              w_dport;
  logic [1:0]        w_chan;
  logic              w_wr;
  logic              w_acc;
  logic              w_adv;
  logic [1:0]        w_ra_ch;
  logic [ADDR_W-1:0] w_ra;
  logic [7:0]        w_rd;
  logic [ADDR_W-1:0] w_ptr [CH];
  logic [7:0]        w_prd [CH];

  assign w_sel   = ~nDEVSEL;
  assign w_dport = is_dport(A, CH);
  assign w_chan  = A[3:2];
  assign w_wr    = w_sel & ~nWE & (s_q == S6);
  assign w_acc   = w_sel & w_dport & (s_q == S6);
  assign w_adv   = (s_q == S1);

  // Pointer channels; each loads its own bytes and advances at S1 if accessed
  for (genvar c = 0; c < CH; c++) begin : g_chan
    logic w_dec;
`ifdef TM_DEC_MODE_EN
    assign w_dec = dir_q[c];
`else
    assign w_dec = 1'b0;
`endif
    tm_ptr_chan #(
      .ADDR_W (ADDR_W),
      .STEP_W (STEP_W)
    ) u_chan (
      .clk_i   (C7M),
      .rst_i   (RES),
      .wr_i    (w_wr & ~w_dport & (w_chan == 2'(c))),
      .byte_i  (A[1:0]),
      .wdata_i (D_in),
      .acc_i   (w_acc & (w_chan == 2'(c))),
      .adv_i   (w_adv),
      .dec_i   (w_dec),
      .step_i  (step_q),
      .ptr_o   (w_ptr[c]),
      .rdata_o (w_prd[c])
    );
  end

  // Address mux: addressed data port, otherwise the last data-port channel used
  always_comb begin
    w_ra_ch = w_dport ? w_chan : last_q;
    w_ra    = '0;
    for (int c = 0; c < CH; c++) begin
      if (w_ra_ch == 2'(c)) w_ra = w_ptr[c];
    end
  end

  // Register-window readback; unmapped offsets and data ports read 0x00
  always_comb begin
    w_rd = 8'h00;
    case (A)
      OFS_STEP: w_rd = 8'(step_q);
`ifdef TM_DEC_MODE_EN
      OFS_DIR:  w_rd = 8'(dir_q);
`endif
      OFS_BANK: w_rd = bank_q;
      default: begin
        for (int c = 0; c < CH; c++) begin
          if ((w_chan == 2'(c)) && (A[1:0] != OFS_DPORT)) w_rd = w_prd[c];
        end
      end
    endcase
  end

  // Bus timing counter, bus-driver windows and global config registers
  always_ff @(posedge C7M or posedge RES) begin
    if (RES) begin
      s_q        <= S0;
      phi1_q     <= 1'b0;
      phi0seen_q <= 1'b0;
      dben_q     <= 1'b0;
      csen_q     <= 1'b0;
      step_q     <= STEP_W'(1);
      bank_q     <= 8'h00;
      dout_q     <= 8'h00;
      last_q     <= 2'd0;
`ifdef TM_DEC_MODE_EN
      dir_q      <= '0;
`endif
    end else begin
      phi1_q <= PHI1;
      if (!PHI1) phi0seen_q <= 1'b1;
      if (PHI1 && !phi1_q && phi0seen_q) begin
        s_q <= S1;
      end else if ((s_q != S0) && (s_q != S7)) begin
        s_q <= s_q + 3'd1;
      end
      dben_q <= (s_q >= S4);
      csen_q <= ((s_q == S4) && nWE) || (s_q >= S5);
      dout_q <= w_rd;
      if (w_acc) last_q <= w_chan;
      if (w_wr) begin
        case (A)
          OFS_STEP: step_q <= D_in[STEP_W-1:0];
`ifdef TM_DEC_MODE_EN
          OFS_DIR:  dir_q  <= D_in[CH-1:0];
`endif
          OFS_BANK: bank_q <= D_in;
          default:  bank_q <= bank_q;
        endcase
      end
    end
  end

  assign RA     = w_ra;
  assign RAMCS  = w_sel & w_dport & csen_q;
  assign RD_sel = w_dport;
  assign D_oe   = dben_q & nWE & w_sel;
  assign D_out  = dout_q;
  assign DBEN   = dben_q;
  assign BANK   = bank_q;

endmodule
`default_nettype wire
